// File: rtl/lane_rr_arbiter.sv
// lane_rr_arbiter: packet-locked round-robin arbiter sharing one packed lane
// bus among NREQ requesters, with a single registered valid/ready output stage.
module lane_rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int W        = 12,
    parameter int HOLD_MAX = 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NREQ-1:0]                        req_valid,
    input  logic [NREQ*W-1:0]                      req_data,
    input  logic [NREQ-1:0]                        req_last,
    output logic [NREQ-1:0]                        req_ready,
    output logic                                   out_valid,
    output logic [W-1:0]                           out_data,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] out_src,
    output logic                                   out_last,
    input  logic                                   out_ready,
    output logic                                   busy
);

    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX - 1);
    localparam logic [SRC_W-1:0] LAST_IDX  = SRC_W'(NREQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic [SRC_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ov_q, ov_d;
    logic [W-1:0]       od_q, od_d;
    logic [SRC_W-1:0]   os_q, os_d;
    logic               ol_q, ol_d;

    logic [W-1:0]       lane_data [NREQ];
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   win_idx;
    logic               win_found;
    logic               accept;
    logic               end_pkt;

    // Unpack the flattened request bus into one lane word per requester.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign lane_data[g] = req_data[g*W +: W];
    end

    // Rotating priority scan: first valid requester starting at ptr.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = SRC_W'((int'(ptr_q) + i) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Handshake outputs: only the granted lane may be ready, gated by output space.
    always_comb begin
        req_ready = '0;
        if (state_q == GRANT) begin
            req_ready[gnt_q] = !ov_q || out_ready;
        end
    end

    assign accept  = (state_q == GRANT) && req_valid[gnt_q] && req_ready[gnt_q];
    // A grant ends on the packet's last beat or when the hold budget runs out.
    assign end_pkt = accept && (req_last[gnt_q] || (cnt_q == CNT_LIMIT));
    assign busy    = (state_q != IDLE) || ov_q;

    // Next-state and output-register update logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        ov_d    = ov_q;
        od_d    = od_q;
        os_d    = os_q;
        ol_d    = ol_q;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_d   = win_idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (end_pkt) begin
                    ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + SRC_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new beat overwrites the output register; consume-and-accept in
        // the same cycle keeps the stream running without a bubble.
        if (accept) begin
            od_d  = lane_data[gnt_q];
            os_d  = gnt_q;
            ov_d  = 1'b1;
            ol_d  = end_pkt;
            cnt_d = cnt_q + CNT_W'(1);
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously so an in-flight beat is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            os_q    <= '0;
            ol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            os_q    <= os_d;
            ol_q    <= ol_d;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_src   = os_q;
    assign out_last  = ol_q;

endmodule

// File: tb/tb_lane_rr_arbiter.sv
// Directed bench for lane_rr_arbiter (NREQ=4, W=12, HOLD_MAX=8).
module tb_lane_rr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 12;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic              out_valid;
    logic [W-1:0]      out_data;
    logic [1:0]        out_src;
    logic              out_last;
    logic              out_ready;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    lane_rr_arbiter #(.NREQ(NREQ), .W(W), .HOLD_MAX(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [W-1:0] d, input logic [1:0] s, input logic l);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_src"},   32'(out_src),   32'(s));
        chk({tag, "_last"},  32'(out_last),  32'(l));
    endtask

    initial begin
        logic [W-1:0] xdata;
        xdata     = 12'bx0z1_xxxx_0000;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_src",   32'(out_src),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        rst_n = 1'b1;
        tick();

        // Single requester 2, three-beat packet
        req_valid = 4'b0100;
        req_data[2*W +: W] = 12'hA5A;
        #1;
        chk("single_ready_bubble", 32'(req_ready), 32'd0);
        tick();
        chk("single_ready_grant", 32'(req_ready), 32'b0100);
        chk("single_busy", 32'(busy), 32'd1);
        tick();
        chk_beat("single_b0", 12'hA5A, 2'd2, 1'b0);
        req_data[2*W +: W] = 12'h3C3;
        tick();
        chk_beat("single_b1", 12'h3C3, 2'd2, 1'b0);
        req_data[2*W +: W] = 12'hFFF;
        req_last = 4'b0100;
        tick();
        chk_beat("single_b2", 12'hFFF, 2'd2, 1'b1);
        chk("single_ready_idle", 32'(req_ready), 32'd0);
        req_valid = '0;
        req_last  = '0;
        tick();
        chk("single_drain_valid", 32'(out_valid), 32'd0);
        chk("single_drain_busy",  32'(busy),      32'd0);

        // Asynchronous reset while a beat is held in the output register
        req_valid = 4'b0010;
        req_data[1*W +: W] = 12'h123;
        tick();
        chk("rstmid_ready", 32'(req_ready), 32'b0010);
        tick();
        chk_beat("rstmid_beat", 12'h123, 2'd1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", 32'(out_valid), 32'd0);
        chk("rstmid_req_ready", 32'(req_ready), 32'd0);
        chk("rstmid_busy",      32'(busy),      32'd0);
        chk("rstmid_out_data",  32'(out_data),  32'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;

        // Round-robin fairness with single-beat packets, ptr restarted at 0
        for (int i = 0; i < NREQ; i++) req_data[i*W +: W] = 12'(12'h100 + i);
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_gap%0d", k), 32'(out_valid), 32'd0);
            tick();
            chk_beat($sformatf("rr_g%0d", k), 12'(12'h100 + (k % 4)), 2'(k % 4), 1'b1);
        end
        req_valid = '0;
        req_last  = '0;
        tick();
        chk("rr_drain", 32'(busy), 32'd0);

        // HOLD_MAX forced rotation: requester 1 streams without last, 3 waits
        req_valid = 4'b1010;
        req_last  = 4'b1000;
        req_data[1*W +: W] = 12'h200;
        req_data[3*W +: W] = 12'h333;
        tick();
        chk("hold_ready", 32'(req_ready), 32'b0010);
        for (int n = 0; n < 8; n++) begin
            tick();
            chk_beat($sformatf("hold_b%0d", n), 12'(12'h200 + n), 2'd1, (n == 7));
            req_data[1*W +: W] = 12'(12'h200 + n + 1);
        end
        tick();
        chk("hold_gap_valid", 32'(out_valid), 32'd0);
        chk("hold_gap_ready", 32'(req_ready), 32'b1000);
        tick();
        chk_beat("hold_r3", 12'h333, 2'd3, 1'b1);
        req_valid = 4'b0010;
        tick();
        chk("hold_gap2_valid", 32'(out_valid), 32'd0);
        tick();
        chk_beat("hold_resume", 12'h208, 2'd1, 1'b0);

        // Backpressure: output stalls for 5 cycles
        req_data[1*W +: W] = 12'h209;
        out_ready = 1'b0;
        #1;
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", c), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold_data%0d", c),  32'(out_data),  32'h208);
            chk($sformatf("bp_hold_ready%0d", c), 32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", 32'(req_ready), 32'b0010);
        tick();
        chk_beat("bp_b1", 12'h209, 2'd1, 1'b0);
        req_data[1*W +: W] = 12'h20A;
        tick();
        chk_beat("bp_b2", 12'h20A, 2'd1, 1'b0);

        // X/Z data passes through bit-exact, then the granted lane stalls
        req_data[1*W +: W] = xdata;
        tick();
        chk("x_data", 32'(out_data), 32'(xdata));
        chk("x_valid", 32'(out_valid), 32'd1);
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("stall_valid%0d", c), 32'(out_valid), 32'd0);
            chk($sformatf("stall_busy%0d", c),  32'(busy),      32'd1);
            chk($sformatf("stall_ready%0d", c), 32'(req_ready), 32'b0010);
        end
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data[1*W +: W] = 12'h2AB;
        tick();
        chk_beat("stall_resume", 12'h2AB, 2'd1, 1'b1);
        req_valid = '0;
        req_last  = '0;
        tick();
        chk("end_valid", 32'(out_valid), 32'd0);
        chk("end_busy",  32'(busy),      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
